// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage with IF/ID pipeline register.
// Holds the PC and fetches over a req/ack memory handshake. It honours a
// hazard stall from ID and a branch/jump redirect, which flushes IF/ID, from EX.
//
// Memory handshake: imem_req is held high with a stable imem_addr until the
// cycle in which imem_ack is seen high. That cycle completes the transfer and
// imem_rdata is sampled then. imem_ack is ignored while imem_req is low.
// After the transfer completes, the FSM may raise imem_req again in the next
// cycle (FETCH) or drop it (HELD).
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] instruction32,
   output logic [31:0] pc_plus4,
   output logic        valid
);

   // FETCH: request outstanding to pc
   // HELD : a word arrived during a stall and is parked in buf_word
   // DRAIN: request outstanding to a stale address; the result is thrown away
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HELD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] buf_word;
   logic [31:0] buf_pc4;
   logic [31:0] pend_pc;
   logic [31:0] pc_inc;
   logic [31:0] target;

   assign pc_inc = pc + 32'd4;
   // Low two bits of the redirect target are forced to zero to keep fetches word aligned.
   assign target = redirect_pc & 32'hFFFF_FFFC;

   // In DRAIN the PC register still holds the stale address, so the address stays stable.
   assign imem_addr = pc;
   // The request is forced low while reset is held. HELD parks a fetched word, so no request is made.
   assign imem_req  = !rst && (state != HELD);

   // Fetch control FSM, PC, holding buffers and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= FETCH;
         pc            <= RESET_PC;
         buf_word      <= 32'd0;
         buf_pc4       <= 32'd0;
         pend_pc       <= 32'd0;
         instruction32 <= NOP;
         pc_plus4      <= 32'd0;
         valid         <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  if (redirect) begin
                     // Wrong-path word: drop it and restart at the target.
                     pc            <= target;
                     instruction32 <= NOP;
                     valid         <= 1'b0;
                  end else if (stall) begin
                     // ID cannot accept the word, so park it and keep IF/ID as it is.
                     buf_word <= imem_rdata;
                     buf_pc4  <= pc_inc;
                     pc       <= pc_inc;
                     state    <= HELD;
                  end else begin
                     instruction32 <= imem_rdata;
                     pc_plus4      <= pc_inc;
                     valid         <= 1'b1;
                     pc            <= pc_inc;
                  end
               end else begin
                  if (redirect) begin
                     // The address must not move mid-request, so wait for the ack in DRAIN.
                     pend_pc       <= target;
                     instruction32 <= NOP;
                     valid         <= 1'b0;
                     state         <= DRAIN;
                  end else if (!stall) begin
                     valid <= 1'b0;
                  end
               end
            end

            HELD: begin
               if (redirect) begin
                  pc            <= target;
                  instruction32 <= NOP;
                  valid         <= 1'b0;
                  state         <= FETCH;
               end else if (!stall) begin
                  instruction32 <= buf_word;
                  pc_plus4      <= buf_pc4;
                  valid         <= 1'b1;
                  state         <= FETCH;
               end
            end

            DRAIN: begin
               // IF/ID stays flushed here. A later redirect replaces the pending target.
               if (imem_ack) begin
                  pc    <= redirect ? target : pend_pc;
                  state <= FETCH;
               end else if (redirect) begin
                  pend_pc <= target;
               end
            end

            default: begin
               state <= FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch. The memory model tags each word with its address.
module tb_instruction_fetch;

   localparam logic [31:0] NOP_W = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] instruction32;
   logic [31:0] pc_plus4;
   logic        valid;
   logic        ack_en;

   // Second instance sitting at the top of the address space for the wrap check.
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_ack;
   logic [31:0] w_rdata;
   logic [31:0] w_instr;
   logic [31:0] w_pc4;
   logic        w_valid;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   // Memory model: zero-wait when ack_en=1, otherwise the request is left pending.
   assign imem_ack   = imem_req & ack_en;
   assign imem_rdata = word_at(imem_addr);
   assign w_ack      = w_req;
   assign w_rdata    = word_at(w_addr);

   instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP(NOP_W)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .instruction32(instruction32), .pc_plus4(pc_plus4), .valid(valid)
   );

   instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP(NOP_W)) dut_wrap (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
      .imem_ack(w_ack), .imem_rdata(w_rdata), .stall(1'b0),
      .redirect(1'b0), .redirect_pc(32'h0000_0000),
      .instruction32(w_instr), .pc_plus4(w_pc4), .valid(w_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a);
      exp_q.push_back({word_at(a), a + 32'd4});
   endtask

   // Scoreboard: each new valid IF/ID value must match the oldest expected delivery.
   logic        prev_v = 1'b0;
   logic [31:0] prev_i = 32'd0;
   logic [31:0] prev_p = 32'd0;
   always @(posedge clk) begin
      logic [63:0] e;
      #2;
      if (!rst && valid === 1'b1 &&
          !(prev_v && prev_i === instruction32 && prev_p === pc_plus4)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_extra observed=%h/%h expected=none", instruction32, pc_plus4);
         end else begin
            e = exp_q.pop_front();
            chk("sb_instr", instruction32, e[63:32]);
            chk("sb_pc4", pc_plus4, e[31:0]);
         end
      end
      prev_v = (valid === 1'b1);
      prev_i = instruction32;
      prev_p = pc_plus4;
   end

   initial begin
      rst = 1'b1; ack_en = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      tick(); tick();
      chk("rst_req", imem_req, 0);
      chk("rst_valid", valid, 0);
      chk("rst_instr", instruction32, NOP_W);
      chk("rst_pc4", pc_plus4, 0);
      chk("rst_wrap_req", w_req, 0);
      rst = 1'b0;
      #1;
      chk("t1_addr0", imem_addr, 32'h0);
      chk("t1_req0", imem_req, 1);

      // Zero-wait back-to-back fetches
      push(32'h0); tick(); chk("t1_addr4", imem_addr, 32'h4);
      push(32'h4); tick(); chk("t1_addr8", imem_addr, 32'h8);
      chk("t1_req", imem_req, 1);

      // Wait states at addr 8
      ack_en = 1'b0;
      repeat (3) begin
         tick();
         chk("t2_addr", imem_addr, 32'h8);
         chk("t2_req", imem_req, 1);
         chk("t2_valid", valid, 0);
      end
      ack_en = 1'b1;
      push(32'h8); tick(); chk("t2_next_addr", imem_addr, 32'hC);

      // Redirect and stall together at an ack: flush wins
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h0;
      tick();
      redirect = 1'b0; stall = 1'b0;
      chk("t5_valid", valid, 0);
      chk("t5_instr", instruction32, NOP_W);
      chk("t5_pc4", pc_plus4, 32'hC);
      chk("t5_addr", imem_addr, 32'h0);
      chk("t5_req", imem_req, 1);

      // Stall for 2 cycles at the ack of addr 4
      push(32'h0); tick(); chk("t3_addr4", imem_addr, 32'h4);
      stall = 1'b1;
      repeat (2) begin
         tick();
         chk("t3_held_req", imem_req, 0);
         chk("t3_held_valid", valid, 1);
         chk("t3_held_instr", instruction32, word_at(32'h0));
         chk("t3_held_pc4", pc_plus4, 32'h4);
      end
      stall = 1'b0;
      push(32'h4); tick();
      chk("t3_rel_addr", imem_addr, 32'h8);
      chk("t3_rel_req", imem_req, 1);
      push(32'h8); tick(); chk("t3_addr12", imem_addr, 32'hC);

      // Redirect while the request at 12 is pending; latest target wins
      ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
      tick();
      chk("t4_valid", valid, 0);
      chk("t4_instr", instruction32, NOP_W);
      chk("t4_addr_a", imem_addr, 32'hC);
      chk("t4_req", imem_req, 1);
      redirect_pc = 32'h41;
      tick();
      redirect = 1'b0;
      chk("t4_addr_b", imem_addr, 32'hC);
      tick();
      chk("t4_addr_c", imem_addr, 32'hC);
      chk("t4_valid_c", valid, 0);
      ack_en = 1'b1;
      tick();
      chk("t4_target", imem_addr, 32'h40);
      chk("t4_drop_valid", valid, 0);
      chk("t4_drop_instr", instruction32, NOP_W);
      push(32'h40); tick(); chk("t4_addr44", imem_addr, 32'h44);

      // Reset while in DRAIN
      ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      chk("t6_drain_req", imem_req, 1);
      chk("t6_drain_addr", imem_addr, 32'h44);
      rst = 1'b1;
      #1;
      chk("t6_rst_req", imem_req, 0);
      chk("t6_rst_valid", valid, 0);
      chk("t6_rst_instr", instruction32, NOP_W);
      chk("t6_rst_wrap_req", w_req, 0);
      tick();
      rst = 1'b0; ack_en = 1'b1;
      #1;
      chk("t6_first_addr", imem_addr, 32'h0);
      chk("t6_wrap_first", w_addr, 32'hFFFF_FFFC);
      push(32'h0); tick();
      ack_en = 1'b0;
      chk("t6_addr4", imem_addr, 32'h4);
      chk("t6_wrap_addr", w_addr, 32'h0);
      chk("t6_wrap_valid", w_valid, 1);
      chk("t6_wrap_instr", w_instr, word_at(32'hFFFF_FFFC));
      chk("t6_wrap_pc4", w_pc4, 32'h0);
      tick();
      chk("t6_wrap_pc4_next", w_pc4, 32'h4);
      chk("t6_wrap_addr_next", w_addr, 32'h4);
      tick();
      chk("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
